// File: rtl/adder_ckt_8bit_pkg.sv
// ============================================================================
// Module      : adder_ckt_8bit_pkg
// Description : Shared datapath width for the regression computation unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_ckt_8bit_pkg;
  localparam int C_DATA_WIDTH = 8;
endpackage

`default_nettype wire

// File: rtl/adder_ckt_8bit_full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder cell used to build the ripple chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

`default_nettype wire

// File: rtl/adder_ckt_8bit.sv
// ============================================================================
// Module      : adder_ckt_8bit
// Description : Ripple-carry adder with combinational and registered results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_ckt_8bit
  import adder_ckt_8bit_pkg::*;
#(
  parameter int WIDTH = C_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum,
  output logic             cy,
  output logic [WIDTH-1:0] sum_q,
  output logic             cy_q,
  output logic             ovf_q,
  output logic             zero_q
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] sum_d;
  logic             cy_d;
  logic             ovf_d;
  logic             zero_d;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (w_c[i]),
      .s    (sum[i]),
      .cout (w_c[i+1])
    );
  end

  assign cy = w_c[WIDTH];

  always_comb begin
    sum_d  = sum;
    cy_d   = w_c[WIDTH];
    // Carries into and out of the sign bit differ exactly on signed overflow.
    ovf_d  = w_c[WIDTH] ^ w_c[WIDTH-1];
    zero_d = ~|sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cy_q   <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cy_q   <= cy_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_ckt_8bit.sv
// ============================================================================
// Module      : tb_adder_ckt_8bit
// Description : Directed vector table, reset sequences and exhaustive sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_ckt_8bit;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cy;
    logic       exp_ovf;
    logic       exp_zero;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] sum;
  logic       cy;
  logic [7:0] sum_q;
  logic       cy_q;
  logic       ovf_q;
  logic       zero_q;

  int checks;
  int failures;

  adder_ckt_8bit #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .sum    (sum),
    .cy     (cy),
    .sum_q  (sum_q),
    .cy_q   (cy_q),
    .ovf_q  (ovf_q),
    .zero_q (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  vec_t vecs[11];

  initial begin
    int sweep_bad;
    logic [8:0] ref_res;

    vecs[0]  = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{8'hB5, 8'hC9, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    A        = 8'h12;
    B        = 8'h34;
    Cin      = 1'b1;

    // Reset state, and combinational path live while in reset
    #2;
    check("reset_sum_q", sum_q, 0);
    check("reset_cy_q", cy_q, 0);
    check("reset_ovf_q", ovf_q, 0);
    check("reset_zero_q", zero_q, 0);
    check("reset_comb_sum", sum, 8'h47);
    @(posedge clk); #1;
    check("reset_hold_sum_q", sum_q, 0);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      A   = vecs[i].a;
      B   = vecs[i].b;
      Cin = vecs[i].cin;
      #1;
      check($sformatf("v%0d_sum", i), sum, vecs[i].exp_sum);
      check($sformatf("v%0d_cy", i), cy, vecs[i].exp_cy);
      @(posedge clk); #1;
      check($sformatf("v%0d_sum_q", i), sum_q, vecs[i].exp_sum);
      check($sformatf("v%0d_cy_q", i), cy_q, vecs[i].exp_cy);
      check($sformatf("v%0d_ovf_q", i), ovf_q, vecs[i].exp_ovf);
      check($sformatf("v%0d_zero_q", i), zero_q, vecs[i].exp_zero);
    end

    // Asynchronous reset mid-cycle while registers hold nonzero values
    @(negedge clk);
    A = 8'hB5; B = 8'hC9; Cin = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_sum_q", sum_q, 8'h7F);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum_q", sum_q, 0);
    check("async_rst_cy_q", cy_q, 0);
    check("async_rst_ovf_q", ovf_q, 0);
    check("async_rst_comb_sum", sum, 8'h7F);
    check("async_rst_comb_cy", cy, 1);
    A = 8'h80; B = 8'h80; Cin = 1'b0;
    #1;
    check("rst_track_sum", sum, 8'h00);
    check("rst_track_cy", cy, 1);
    @(posedge clk); #1;
    check("rst_edge_sum_q", sum_q, 0);
    check("rst_edge_cy_q", cy_q, 0);
    check("rst_edge_zero_q", zero_q, 0);

    // First edge after release loads the current result
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_edge_zero_q", zero_q, 0);
    @(posedge clk); #1;
    check("first_edge_sum_q", sum_q, 8'h00);
    check("first_edge_cy_q", cy_q, 1);
    check("first_edge_ovf_q", ovf_q, 1);
    check("first_edge_zero_q", zero_q, 1);

    // Exhaustive combinational sweep against an arithmetic reference
    sweep_bad = 0;
    for (int n = 0; n < (1 << 17); n++) begin
      A   = n[7:0];
      B   = n[15:8];
      Cin = n[16];
      #1;
      ref_res = {1'b0, n[7:0]} + {1'b0, n[15:8]} + {8'd0, n[16]};
      if ({cy, sum} !== ref_res) begin
        if (sweep_bad < 4)
          $display("note sweep A=%0h B=%0h Cin=%0b got=%0h want=%0h", A, B, Cin, {cy, sum}, ref_res);
        sweep_bad++;
      end
    end
    check("sweep_mismatch_count", sweep_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
